// File: rtl/branch_cmp_pkg.sv
// Shared types and helpers for the iterative branch compare unit.
package branch_cmp_pkg;

    typedef struct packed {
        logic lt;
        logic invert;
        logic unsigned_comparison;
    } cmp_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int xlen, input int chunk);
        return xlen / chunk;
    endfunction

    // Signedness is folded into the operands (MSB flip), so only lt/invert matter here.
    function automatic logic op_taken(input cmp_op_t op, input logic eq, input logic a_lt_b);
        logic cond;
        cond = op.lt ? a_lt_b : eq;
        return cond ^ op.invert;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one operand chunk.
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         lt_o
);

    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/branch_cmp_iter.sv
// Multi-cycle RISC-V branch compare, CHUNK bits per cycle, MSB chunk first.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first deciding chunk instead of constant time.
module branch_cmp_iter
    import branch_cmp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ra,
    input  logic [XLEN-1:0] rb,
    input  logic            lt,
    input  logic            invert,
    input  logic            unsigned_comparison,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken
);

    localparam int NCHUNK = nchunk(XLEN, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] a_q, b_q;
    cmp_op_t         op_q, op_in;
    logic [XLEN-1:0] sign_mask;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic            accept, c_eq, c_lt;
    logic            finish, res_eq, res_lt;

    assign op_in     = {lt, invert, unsigned_comparison};
    assign sign_mask = {(lt && !unsigned_comparison), {(XLEN-1){1'b0}}};
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready && !kill;
    assign out_valid = (state_q == S_DONE);
    assign taken     = taken_q;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a_i  (a_chunk),
        .b_i  (b_chunk),
        .eq_o (c_eq),
        .lt_o (c_lt)
    );

`ifdef CMP_EARLY_EXIT_EN
    assign finish = !c_eq || (idx_q == '0);
    assign res_eq = c_eq;
    assign res_lt = c_lt;
`else
    // Constant time: hold the first differing chunk's verdict until the last chunk.
    logic dec_q, dec_lt_q;

    assign finish = (idx_q == '0);
    assign res_eq = dec_q ? 1'b0 : c_eq;
    assign res_lt = dec_q ? dec_lt_q : c_lt;

    always_ff @(posedge clk) begin
        if (rst || accept || kill) begin
            dec_q <= 1'b0;
        end else if (state_q == S_BUSY && !dec_q && !c_eq) begin
            dec_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_BUSY && !dec_q && !c_eq) begin
            dec_lt_q <= c_lt;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        taken_d = taken_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    idx_d   = IDX_TOP;
                end
            end
            S_BUSY: begin
                if (finish) begin
                    state_d = S_DONE;
                    taken_d = op_taken(op_q, res_eq, res_lt);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A killed request must not disturb the visible result.
        if (kill) begin
            state_d = S_IDLE;
            taken_d = taken_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_TOP;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            taken_q <= taken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= ra ^ sign_mask;
            b_q  <= rb ^ sign_mask;
            op_q <= op_in;
        end
    end

endmodule

// File: tb/tb_branch_cmp_iter.sv
// Scoreboard bench for branch_cmp_iter (XLEN=32, CHUNK=8), either early-exit build.
module tb_branch_cmp_iter;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] ra = '0;
    logic [XLEN-1:0] rb = '0;
    logic            lt = 1'b0;
    logic            invert = 1'b0;
    logic            unsigned_comparison = 1'b0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic taken;
        int   lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_cmp_iter #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .ra                  (ra),
        .rb                  (rb),
        .lt                  (lt),
        .invert              (invert),
        .unsigned_comparison (unsigned_comparison),
        .kill                (kill),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .taken               (taken)
    );

    function automatic logic model_taken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic c;
        if (!op[2])     c = (a == b);
        else if (op[0]) c = (a < b);
        else            c = ($signed(a) < $signed(b));
        return c ^ op[1];
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_EARLY_EXIT_EN
        for (int k = NCHUNK - 1; k >= 0; k--) begin
            if (a[k*CHUNK +: CHUNK] != b[k*CHUNK +: CHUNK]) return (NCHUNK - k) + 1;
        end
        return NCHUNK + 1;
`else
        if (a == b) return NCHUNK + 1;
        return NCHUNK + 1;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input int hold, input string name);
        exp_t e;
        int   cyc;
        logic t0;
        e.taken = model_taken(a, b, op);
        e.lat   = model_lat(a, b);
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready actual=%b required=1", name, in_ready);
        end
        ra = a; rb = b; {lt, invert, unsigned_comparison} = op;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%b required=1 within 40 cycles", name, out_valid);
        end else begin
            if (cyc !== e.lat) begin
                errors++;
                $display("FAIL %s_latency actual=%0d required=%0d", name, cyc, e.lat);
            end
            checks++;
            if (taken !== e.taken) begin
                errors++;
                $display("FAIL %s_taken actual=%b required=%b", name, taken, e.taken);
            end
            t0 = taken;
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || taken !== t0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_hold out_valid=%b taken=%b in_ready=%b required 1,%b,0",
                             name, out_valid, taken, in_ready, t0);
                end
            end
            out_ready = 1'b1;
            if (hold > 0) in_valid = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_post_handshake out_valid=%b in_ready=%b required 0,1",
                         name, out_valid, in_ready);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b taken=%b required 0,0,0",
                     in_ready, out_valid, taken);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_ops();
        run_op(32'h12345678, 32'h12345678, 3'b000, 0, "eq_equal");
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b100, 0, "lt_signed");
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b101, 0, "ltu");
        run_op(32'h00000100, 32'h000000FF, 3'b111, 0, "geu");
        run_op(32'h80000000, 32'h80000001, 3'b010, 0, "ne");
        run_op(32'h80000000, 32'h80000001, 3'b110, 0, "ge_signed");
        run_op(32'h7FFFFFFF, 32'h80000000, 3'b100, 0, "lt_signed_extreme");
        run_op(32'h00000005, 32'h00000005, 3'b111, 0, "geu_equal");
    endtask

    task automatic test_backpressure();
        run_op(32'hABCD0000, 32'hABCD0001, 3'b101, 3, "backpressure");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < 10; i++) begin
            a  = $urandom;
            case (i % 3)
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            op = 3'($urandom_range(0, 7));
            run_op(a, b, op, i % 2, "random");
        end
    endtask

    task automatic test_kill_busy();
        int seen = 0;
        @(negedge clk);
        ra = 32'h12345678; rb = 32'h12345678; {lt, invert, unsigned_comparison} = 3'b000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy in_ready=%b out_valid=%b required 1,0", in_ready, out_valid);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_busy_no_output out_valid_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_rst_in_done();
        int cyc = 0;
        @(negedge clk);
        ra = 32'h00000042; rb = 32'h00000042; {lt, invert, unsigned_comparison} = 3'b000;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1 || taken !== 1'b1) begin
            errors++;
            $display("FAIL rst_done_setup out_valid=%b taken=%b required 1,1", out_valid, taken);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || taken !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_done out_valid=%b taken=%b in_ready=%b required 0,0,0",
                     out_valid, taken, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_kill_idle();
        int seen = 0;
        @(negedge clk);
        ra = 32'h1; rb = 32'h1; {lt, invert, unsigned_comparison} = 3'b000;
        in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle_in_ready actual=%b required=1", in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_idle_no_output out_valid_cycles=%0d required=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_kill_busy();
        test_rst_in_done();
        test_kill_idle();
        test_random();
        test_ops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
